// File: rtl/seq_word_adder_pkg.sv
// Shared types and constants for the sequential slice-wise word adder.
package seq_word_adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rip_carry.sv
// 4-bit ripple-carry adder used as the slice adder.
module rip_carry (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);

    always_comb begin : ripple
        logic c;
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry = c;
    end

endmodule

// File: rtl/seq_word_adder.sv
// Adds two WIDTH-bit words one 4-bit slice per cycle through a single
// ripple-carry slice adder, with valid/ready handshakes on both sides.
module seq_word_adder
    import seq_word_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned N     = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("seq_word_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_carry;

    // Select the operand slice addressed by idx.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    rip_carry u_slice_add (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
                    end
                end
                carry_d = slice_carry;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    cout_d  = slice_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
